// File: rtl/rtc_alarm_core_if.sv
// Board-side signal bundle of the RTC/alarm core: button/switch inputs in,
// seven-segment drive, ring and time observation out.
interface rtc_alarm_core_if;
    logic        mode12;
    logic [1:0]  view;
    logic        set_sel;
    logic        inc_h;
    logic        inc_m;
    logic        alarm_en;
    logic        snooze;
    logic [3:0]  an;
    logic [6:0]  atog;
    logic        dp;
    logic        ring;
    logic        sec_tick;
    logic [23:0] time_bcd;

    modport master (
        output mode12, view, set_sel, inc_h, inc_m, alarm_en, snooze,
        input  an, atog, dp, ring, sec_tick, time_bcd
    );

    modport slave (
        input  mode12, view, set_sel, inc_h, inc_m, alarm_en, snooze,
        output an, atog, dp, ring, sec_tick, time_bcd
    );
endinterface

// File: rtl/rtc_alarm_core.sv
// BCD real-time clock with alarm/snooze FSM and a directly driven 4-digit
// multiplexed seven-segment display. Time is kept in 24 h BCD internally.
module rtc_alarm_core #(
    parameter int TICK_DIV   = 50000000,
    parameter int SCAN_BITS  = 15,
    parameter int RING_SECS  = 30,
    parameter int SNOOZE_MIN = 5
) (
    input  logic             clk,
    input  logic             clr_n,
    rtc_alarm_core_if.slave  bus
);
    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRESC_HALF = PW'(TICK_DIV / 2);
    localparam logic [3:0]     SN_T       = 4'(SNOOZE_MIN / 10);
    localparam logic [3:0]     SN_U       = 4'(SNOOZE_MIN % 10);
    localparam logic [7:0]     RING_LAST  = 8'(RING_SECS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    // Increment a BCD digit pair, wrapping to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)             return 8'h00;
        if (v[3:0] == 4'd9)       return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] to_12h(input logic [7:0] h);
        if (h == 8'h00)                          return 8'h12;
        if (h[7:4] == 4'd1 && h[3:0] >= 4'd3)    return {4'd0, h[3:0] - 4'd2};
        if (h[7:4] == 4'd2 && h[3:0] <= 4'd1)    return {4'd0, h[3:0] + 4'd8};
        if (h[7:4] == 4'd2)                      return {4'd1, h[3:0] - 4'd2};
        return h;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    logic [PW-1:0]        presc_q, presc_d;
    logic [SCAN_BITS-1:0] scan_q, scan_d;
    logic [7:0]           hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic [7:0]           al_hh_q, al_hh_d, al_mm_q, al_mm_d;
    logic [7:0]           tgt_hh_q, tgt_hh_d, tgt_mm_q, tgt_mm_d;
    logic [1:0]           st_q, st_d;
    logic [7:0]           ring_cnt_q, ring_cnt_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           atog_q, atog_d;
    logic                 dp_q, dp_d;

    logic       tick, carry_s, carry_m, edit_m, edit_h;
    logic       match_alarm, match_snz;
    logic [4:0] sum_u, sum_t;
    logic [7:0] snz_hh, snz_mm;

    // Timekeeping and edit path.
    always_comb begin
        // NOTE: every combinational output gets a default up front so no path can infer a latch.
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PW'(1);
        scan_d  = scan_q + SCAN_BITS'(1);

        edit_m  = bus.inc_m && !bus.set_sel;
        edit_h  = bus.inc_h && !bus.set_sel;
        carry_s = tick && (ss_q == 8'h59);
        carry_m = carry_s && !edit_m && (mm_q == 8'h59);

        ss_d    = tick ? bcd_inc(ss_q, 8'h59) : ss_q;
        // An edit and a tick carry both mean +1, so the carry is simply absorbed.
        mm_d    = (edit_m || carry_s) ? bcd_inc(mm_q, 8'h59) : mm_q;
        hh_d    = (edit_h || carry_m) ? bcd_inc(hh_q, 8'h23) : hh_q;

        al_mm_d = (bus.inc_m && bus.set_sel) ? bcd_inc(al_mm_q, 8'h59) : al_mm_q;
        al_hh_d = (bus.inc_h && bus.set_sel) ? bcd_inc(al_hh_q, 8'h23) : al_hh_q;

        match_alarm = tick && ({hh_d, mm_d, ss_d} == {al_hh_q, al_mm_q, 8'h00});
        match_snz   = tick && ({hh_d, mm_d, ss_d} == {tgt_hh_q, tgt_mm_q, 8'h00});
    end

    // Snooze target: current hh:mm plus SNOOZE_MIN, digit-wise BCD add.
    always_comb begin
        sum_u = {1'b0, mm_q[3:0]} + {1'b0, SN_U};
        if (sum_u > 5'd9) sum_u = sum_u - 5'd10;
        sum_t = {1'b0, mm_q[7:4]} + {1'b0, SN_T}
              + {4'd0, ({1'b0, mm_q[3:0]} + {1'b0, SN_U}) > 5'd9};
        snz_hh = hh_q;
        if (sum_t > 5'd5) begin
            sum_t  = sum_t - 5'd6;
            snz_hh = bcd_inc(hh_q, 8'h23);
        end
        snz_mm = {sum_t[3:0], sum_u[3:0]};
    end

    always_comb begin
        st_d       = st_q;
        ring_cnt_d = ring_cnt_q;
        tgt_hh_d   = tgt_hh_q;
        tgt_mm_d   = tgt_mm_q;
        if (!bus.alarm_en) begin
            st_d = ST_IDLE;
        end else begin
            case (st_q)
                ST_IDLE: if (match_alarm) begin
                    st_d       = ST_RING;
                    ring_cnt_d = '0;
                end
                ST_RING: if (bus.snooze) begin
                    st_d     = ST_SNOOZE;
                    tgt_hh_d = snz_hh;
                    tgt_mm_d = snz_mm;
                end else if (tick) begin
                    if (ring_cnt_q == RING_LAST) st_d = ST_IDLE;
                    else                         ring_cnt_d = ring_cnt_q + 8'd1;
                end
                ST_SNOOZE: if (match_snz) begin
                    st_d       = ST_RING;
                    ring_cnt_d = '0;
                end
                default: st_d = ST_IDLE;
            endcase
        end
    end

    logic [1:0]  sel;
    logic [7:0]  src_hh, src_mm, disp_hh;
    logic [3:0]  hh_tens, nib;
    logic [15:0] digits;
    logic        dp_lit;

    // Display: digit 3 leftmost, 0xF in a nibble means blank.
    always_comb begin
        sel     = scan_q[SCAN_BITS-1 -: 2];
        src_hh  = (bus.view == 2'd1) ? al_hh_q : hh_q;
        src_mm  = (bus.view == 2'd1) ? al_mm_q : mm_q;
        disp_hh = bus.mode12 ? to_12h(src_hh) : src_hh;
        hh_tens = (bus.mode12 && disp_hh[7:4] == 4'd0) ? 4'hF : disp_hh[7:4];
        case (bus.view)
            2'd0, 2'd1: digits = {hh_tens, disp_hh[3:0], src_mm};
            2'd2:       digits = {mm_q, ss_q};
            default:    digits = 16'hFFFF;
        endcase
        nib    = digits[{sel, 2'b00} +: 4];
        dp_lit = (sel == 2'd2 && !bus.view[0] && bus.view != 2'd3 && presc_q < PRESC_HALF)
              || (sel == 2'd0 && bus.mode12 && !bus.view[1] && src_hh >= 8'h12);
        an_d   = (bus.view == 2'd3) ? 4'hF : ~(4'b0001 << sel);
        atog_d = seg7(nib);
        dp_d   = ~dp_lit;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            presc_q    <= '0;
            scan_q     <= '0;
            hh_q       <= 8'h00;
            mm_q       <= 8'h00;
            ss_q       <= 8'h00;
            al_hh_q    <= 8'h00;
            al_mm_q    <= 8'h00;
            tgt_hh_q   <= 8'h00;
            tgt_mm_q   <= 8'h00;
            st_q       <= ST_IDLE;
            ring_cnt_q <= '0;
            an_q       <= 4'hF;
            atog_q     <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            scan_q     <= scan_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            al_hh_q    <= al_hh_d;
            al_mm_q    <= al_mm_d;
            tgt_hh_q   <= tgt_hh_d;
            tgt_mm_q   <= tgt_mm_d;
            st_q       <= st_d;
            ring_cnt_q <= ring_cnt_d;
            an_q       <= an_d;
            atog_q     <= atog_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.sec_tick = tick;
    assign bus.ring     = (st_q == ST_RING);
    assign bus.time_bcd = {hh_q, mm_q, ss_q};
    assign bus.an       = an_q;
    assign bus.atog     = atog_q;
    assign bus.dp       = dp_q;
endmodule

// File: tb/tb_rtc_alarm_core.sv
// Self-checking bench for rtc_alarm_core: directed scenarios plus random
// stimulus, all compared against a seconds/minutes arithmetic reference model.
module tb_rtc_alarm_core;
    localparam int TD = 4;
    localparam int SB = 4;
    localparam int RS = 3;
    localparam int SN = 5;
    localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    rtc_alarm_core_if bus ();

    rtc_alarm_core #(
        .TICK_DIV  (TD),
        .SCAN_BITS (SB),
        .RING_SECS (RS),
        .SNOOZE_MIN(SN)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers for time of day and alarm.
    int h, m, s, ah, am, presc, scan, mst, ring_ticks, tgt;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int tick_seen, ring_hi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] on;
        case (d)
            0: on = 7'b1111110;
            1: on = 7'b0110000;
            2: on = 7'b1101101;
            3: on = 7'b1111001;
            4: on = 7'b0110011;
            5: on = 7'b1011011;
            6: on = 7'b1011111;
            7: on = 7'b1110000;
            8: on = 7'b1111111;
            9: on = 7'b1111011;
            default: on = 7'b0000000;
        endcase
        return ~on;
    endfunction

    function automatic logic [7:0] bcd2(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [23:0] bcd_time(input int hh, input int mm, input int ss);
        return {bcd2(hh), bcd2(mm), bcd2(ss)};
    endfunction

    task automatic model_reset();
        h = 0; m = 0; s = 0; ah = 0; am = 0;
        presc = 0; scan = 0; mst = M_IDLE; ring_ticks = 0; tgt = 0;
    endtask

    task automatic predict_display();
        int sel, v, hs, ms, dh;
        int d[4];
        logic lit;
        if (!clr_n) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            return;
        end
        sel = (scan >> (SB - 2)) & 3;
        v   = int'(bus.view);
        hs  = (v == 1) ? ah : h;
        ms  = (v == 1) ? am : m;
        if (v <= 1) begin
            dh   = bus.mode12 ? ((hs % 12 == 0) ? 12 : hs % 12) : hs;
            d[3] = (bus.mode12 && dh < 10) ? 15 : dh / 10;
            d[2] = dh % 10;
            d[1] = ms / 10;
            d[0] = ms % 10;
        end else if (v == 2) begin
            d[3] = m / 10; d[2] = m % 10; d[1] = s / 10; d[0] = s % 10;
        end else begin
            d[3] = 15; d[2] = 15; d[1] = 15; d[0] = 15;
        end
        lit   = (sel == 2 && (v == 0 || v == 2) && presc < TD / 2)
             || (sel == 0 && bus.mode12 && v <= 1 && hs >= 12);
        e_an  = (v == 3) ? 4'hF : ~(4'b0001 << sel);
        e_seg = seg_of(d[sel]);
        e_dp  = ~lit;
    endtask

    task automatic model_edge(input logic ih, input logic im, input logic sz);
        int nh, nm, ns;
        bit tick, alarm_hit, snz_hit, edit_m, edit_h;
        if (!clr_n) begin
            model_reset();
            return;
        end
        scan   = (scan + 1) % (1 << SB);
        tick   = (presc == TD - 1);
        presc  = tick ? 0 : presc + 1;
        edit_m = im && !bus.set_sel;
        edit_h = ih && !bus.set_sel;
        nh = h; nm = m; ns = s;
        if (tick) begin
            ns = s + 1;
            if (ns == 60) begin
                ns = 0;
                if (!edit_m) begin
                    nm = m + 1;
                    if (nm == 60) begin
                        nm = 0;
                        if (!edit_h) nh = (h + 1) % 24;
                    end
                end
            end
        end
        if (edit_m) nm = (m + 1) % 60;
        if (edit_h) nh = (h + 1) % 24;
        alarm_hit = tick && nh == ah && nm == am && ns == 0;
        snz_hit   = tick && nh * 60 + nm == tgt && ns == 0;
        if (!bus.alarm_en) begin
            mst = M_IDLE;
        end else if (mst == M_IDLE && alarm_hit) begin
            mst = M_RING; ring_ticks = 0;
        end else if (mst == M_RING) begin
            if (sz) begin
                mst = M_SNOOZE;
                tgt = (h * 60 + m + SN) % 1440;
            end else if (tick) begin
                ring_ticks++;
                if (ring_ticks == RS) mst = M_IDLE;
            end
        end else if (mst == M_SNOOZE && snz_hit) begin
            mst = M_RING; ring_ticks = 0;
        end
        if (bus.set_sel) begin
            if (im) am = (am + 1) % 60;
            if (ih) ah = (ah + 1) % 24;
        end
        h = nh; m = nm; s = ns;
    endtask

    // One clock: called and returning at posedge+1.
    task automatic step(input logic ih, input logic im, input logic sz);
        bus.inc_h  = ih;
        bus.inc_m  = im;
        bus.snooze = sz;
        #2;
        check("sec_tick", 32'(bus.sec_tick), 32'(presc == TD - 1));
        if (bus.sec_tick === 1'b1) tick_seen++;
        predict_display();
        @(posedge clk);
        model_edge(ih, im, sz);
        #1;
        check("ring", 32'(bus.ring), 32'(mst == M_RING));
        check("time_bcd", 32'(bus.time_bcd), 32'(bcd_time(h, m, s)));
        check("an", 32'(bus.an), 32'(e_an));
        check("atog", 32'(bus.atog), 32'(e_seg));
        check("dp", 32'(bus.dp), 32'(e_dp));
        if (bus.ring === 1'b1) ring_hi++;
        bus.inc_h  = 1'b0;
        bus.inc_m  = 1'b0;
        bus.snooze = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        clr_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        clr_n = 1'b1;
    endtask

    task automatic wait_ring(input string tag, input logic level, input int bound);
        int k = 0;
        while (bus.ring !== level && k < bound) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        check(tag, 32'(bus.ring), 32'(level));
    endtask

    task automatic wait_digit(input int idx);
        logic [3:0] want;
        int k = 0;
        want = ~(4'b0001 << idx);
        step(1'b0, 1'b0, 1'b0);
        while (bus.an !== want && k < 20) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        check("digit_select", 32'(bus.an), 32'(want));
    endtask

    task automatic wait_sec59_tick(input int bound);
        int k = 0;
        while (!(s == 59 && presc == TD - 1) && k < bound) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int h0, m0, a0, k;
        bus.mode12 = 1'b0; bus.view = 2'd0; bus.set_sel = 1'b0;
        bus.inc_h = 1'b0; bus.inc_m = 1'b0; bus.alarm_en = 1'b0; bus.snooze = 1'b0;
        tick_seen = 0; ring_hi = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check("rst_time", 32'(bus.time_bcd), 32'h0);
        check("rst_an", 32'(bus.an), 32'hF);
        check("rst_atog", 32'(bus.atog), 32'h7F);
        check("rst_dp", 32'(bus.dp), 32'h1);
        check("rst_ring", 32'(bus.ring), 32'h0);
        check("rst_tick", 32'(bus.sec_tick), 32'h0);
        clr_n = 1'b1;

        // Preset 23:59, let seconds reach 58, then two ticks wrap the day.
        repeat (23) step(1'b1, 1'b0, 1'b0);
        repeat (59) step(1'b0, 1'b1, 1'b0);
        k = 0;
        while (!(h == 23 && m == 59 && s == 58 && presc == 0) && k < 400) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        check("preset_235958", 32'(bus.time_bcd), 32'h235958);
        tick_seen = 0;
        run(8);
        check("day_wrap", 32'(bus.time_bcd), 32'h000000);
        check("tick_count_8cyc", 32'(tick_seen), 32'd2);

        // 12 h display: 00:05 then 13:05.
        bus.mode12 = 1'b1;
        bus.view   = 2'd0;
        repeat (5) step(1'b0, 1'b1, 1'b0);
        wait_digit(0);
        check("h12_min_units", 32'(bus.atog), 32'(seg_of(5)));
        check("h12_am_dp", 32'(bus.dp), 32'h1);
        wait_digit(3);
        check("h12_midnight_tens", 32'(bus.atog), 32'(seg_of(1)));
        wait_digit(2);
        check("h12_midnight_units", 32'(bus.atog), 32'(seg_of(2)));
        repeat (13) step(1'b1, 1'b0, 1'b0);
        wait_digit(3);
        check("h12_tens_blank", 32'(bus.atog), 32'h7F);
        wait_digit(2);
        check("h12_pm_units", 32'(bus.atog), 32'(seg_of(1)));
        wait_digit(0);
        check("h12_pm_dp", 32'(bus.dp), 32'h0);
        bus.mode12 = 1'b0;

        // Alarm 07:30 with time preset to 07:29:xx.
        pulse_reset();
        repeat (7) step(1'b1, 1'b0, 1'b0);
        repeat (29) step(1'b0, 1'b1, 1'b0);
        bus.set_sel = 1'b1;
        repeat (7) step(1'b1, 1'b0, 1'b0);
        repeat (30) step(1'b0, 1'b1, 1'b0);
        bus.set_sel = 1'b0;
        bus.alarm_en = 1'b1;
        wait_ring("ring_rise", 1'b1, 400);
        check("ring_rise_time", 32'(bus.time_bcd), 32'h073000);
        wait_ring("ring_timeout", 1'b0, 40);
        check("ring_timeout_time", 32'(bus.time_bcd), 32'h073003);

        // Snooze: alarm 07:31, snooze at 07:31:01, ring again at 07:36:00.
        bus.set_sel = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        bus.set_sel = 1'b0;
        wait_ring("ring2_rise", 1'b1, 300);
        check("ring2_time", 32'(bus.time_bcd), 32'h073100);
        run(4);
        step(1'b0, 1'b0, 1'b1);
        check("snooze_drop", 32'(bus.ring), 32'h0);
        wait_ring("snooze_rering", 1'b1, 1300);
        check("snooze_rering_time", 32'(bus.time_bcd), 32'h073600);
        step(1'b0, 1'b0, 1'b1);
        bus.alarm_en = 1'b0;
        run(2);
        bus.alarm_en = 1'b1;
        ring_hi = 0;
        run(1260);
        check("no_ring_after_disable", 32'(ring_hi), 32'd0);

        // inc_m on the tick that would carry seconds into minutes.
        wait_sec59_tick(300);
        h0 = h; m0 = m;
        step(1'b0, 1'b1, 1'b0);
        check("edit_absorbs_carry", 32'(bus.time_bcd), 32'(bcd_time(h0, (m0 + 1) % 60, 0)));
        bus.set_sel = 1'b1;
        wait_sec59_tick(300);
        h0 = h; m0 = m; a0 = am;
        step(1'b0, 1'b1, 1'b0);
        check("alarm_edit_time_carries", 32'(bus.time_bcd),
              32'(bcd_time((m0 == 59) ? (h0 + 1) % 24 : h0, (m0 + 1) % 60, 0)));
        bus.set_sel = 1'b0;
        bus.view = 2'd1;
        wait_digit(0);
        check("alarm_min_digit", 32'(bus.atog), 32'(seg_of(((a0 + 1) % 60) % 10)));
        bus.view = 2'd0;

        // Reset in the middle of ringing.
        pulse_reset();
        bus.set_sel = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        bus.set_sel = 1'b0;
        wait_ring("ring3_rise", 1'b1, 300);
        pulse_reset();
        check("rst_ring_drop", 32'(bus.ring), 32'h0);
        check("rst_ring_time", 32'(bus.time_bcd), 32'h0);
        check("rst_ring_an", 32'(bus.an), 32'hF);
        check("rst_ring_atog", 32'(bus.atog), 32'h7F);

        // Random traffic; alarm armed for 00:01 so the FSM gets exercised.
        bus.set_sel = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            bus.view     = 2'($urandom_range(0, 3));
            bus.mode12   = 1'($urandom_range(0, 1));
            bus.set_sel  = 1'($urandom_range(0, 1));
            bus.alarm_en = ($urandom_range(0, 31) != 0);
            clr_n        = ($urandom_range(0, 499) != 0);
            step($urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 7) == 0);
            clr_n = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
